// File: rtl/operand_fetch.sv
// Operand fetch stage between decode and execute: drives register-file reads and forwards writebacks.
// Optional performance counters are compiled in when OPERAND_FETCH_PERF_EN is defined.
module operand_fetch #(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [4:0]       rf_rs1_addr,
    output logic [4:0]       rf_rs2_addr,
    input  logic [31:0]      rf_rs1_data,
    input  logic [31:0]      rf_rs2_data,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_rs1_data,
    output logic [31:0]      out_rs2_data,
    output logic [TAG_W-1:0] out_tag
`ifdef OPERAND_FETCH_PERF_EN
    ,
    output logic [31:0]      perf_fwd_cnt,
    output logic [31:0]      perf_stall_cnt
`endif
);

    logic             s1_valid_q, s1_valid_d;
    logic [4:0]       s1_rs1_q, s1_rs1_d, s1_rs2_q, s1_rs2_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s1_fwd1_q, s1_fwd1_d, s1_fwd2_q, s1_fwd2_d;
    logic [31:0]      s1_fwd_data1_q, s1_fwd_data1_d, s1_fwd_data2_q, s1_fwd_data2_d;

    logic             out_valid_q, out_valid_d;
    logic [4:0]       out_rs1_addr_q, out_rs1_addr_d, out_rs2_addr_q, out_rs2_addr_d;
    logic [31:0]      out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic        wb_ok, s2_free, accept, xfer;
    logic        hit1_now, hit2_now, fwd_evt;
    logic [31:0] op1, op2;

    assign wb_ok = wb_en && (wb_addr != 5'd0);

    always_comb begin
        s2_free     = !out_valid_q || out_ready;
        in_ready    = !s1_valid_q || s2_free;
        rf_rs1_addr = in_ready ? in_rs1 : s1_rs1_q;
        rf_rs2_addr = in_ready ? in_rs2 : s1_rs2_q;
        accept      = in_valid && in_ready;
        xfer        = s1_valid_q && s2_free;

        // A write landing this cycle is newer than anything captured or read back.
        hit1_now = wb_ok && (wb_addr == s1_rs1_q);
        hit2_now = wb_ok && (wb_addr == s1_rs2_q);

        if (s1_rs1_q == 5'd0)  op1 = 32'd0;
        else if (hit1_now)     op1 = wb_data;
        else if (s1_fwd1_q)    op1 = s1_fwd_data1_q;
        else                   op1 = rf_rs1_data;

        if (s1_rs2_q == 5'd0)  op2 = 32'd0;
        else if (hit2_now)     op2 = wb_data;
        else if (s1_fwd2_q)    op2 = s1_fwd_data2_q;
        else                   op2 = rf_rs2_data;

        fwd_evt = xfer && !flush &&
                  (((s1_rs1_q != 5'd0) && (hit1_now || s1_fwd1_q)) ||
                   ((s1_rs2_q != 5'd0) && (hit2_now || s1_fwd2_q)));
    end

    always_comb begin
        s1_valid_d     = s1_valid_q;
        s1_rs1_d       = s1_rs1_q;
        s1_rs2_d       = s1_rs2_q;
        s1_tag_d       = s1_tag_q;
        s1_fwd1_d      = s1_fwd1_q;
        s1_fwd2_d      = s1_fwd2_q;
        s1_fwd_data1_d = s1_fwd_data1_q;
        s1_fwd_data2_d = s1_fwd_data2_q;

        if (flush) begin
            s1_valid_d = 1'b0;
        end else begin
            // The file returns pre-write data next cycle, so capture the write now.
            s1_fwd1_d = wb_ok && (wb_addr == rf_rs1_addr);
            s1_fwd2_d = wb_ok && (wb_addr == rf_rs2_addr);
            if (s1_fwd1_d) s1_fwd_data1_d = wb_data;
            if (s1_fwd2_d) s1_fwd_data2_d = wb_data;
            if (accept) begin
                s1_valid_d = 1'b1;
                s1_rs1_d   = in_rs1;
                s1_rs2_d   = in_rs2;
                s1_tag_d   = in_tag;
            end else if (xfer) begin
                s1_valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        out_valid_d    = out_valid_q;
        out_rs1_addr_d = out_rs1_addr_q;
        out_rs2_addr_d = out_rs2_addr_q;
        out_rs1_d      = out_rs1_q;
        out_rs2_d      = out_rs2_q;
        out_tag_d      = out_tag_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (xfer) begin
            out_valid_d    = 1'b1;
            out_rs1_addr_d = s1_rs1_q;
            out_rs2_addr_d = s1_rs2_q;
            out_rs1_d      = op1;
            out_rs2_d      = op2;
            out_tag_d      = s1_tag_q;
        end else if (out_valid_q && !out_ready) begin
            // Held operands keep tracking the architectural register value.
            if (wb_ok && (wb_addr == out_rs1_addr_q)) out_rs1_d = wb_data;
            if (wb_ok && (wb_addr == out_rs2_addr_q)) out_rs2_d = wb_data;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q     <= 1'b0;
            s1_rs1_q       <= 5'd0;
            s1_rs2_q       <= 5'd0;
            s1_tag_q       <= '0;
            s1_fwd1_q      <= 1'b0;
            s1_fwd2_q      <= 1'b0;
            s1_fwd_data1_q <= 32'd0;
            s1_fwd_data2_q <= 32'd0;
            out_valid_q    <= 1'b0;
            out_rs1_addr_q <= 5'd0;
            out_rs2_addr_q <= 5'd0;
            out_rs1_q      <= 32'd0;
            out_rs2_q      <= 32'd0;
            out_tag_q      <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_rs1_q       <= s1_rs1_d;
            s1_rs2_q       <= s1_rs2_d;
            s1_tag_q       <= s1_tag_d;
            s1_fwd1_q      <= s1_fwd1_d;
            s1_fwd2_q      <= s1_fwd2_d;
            s1_fwd_data1_q <= s1_fwd_data1_d;
            s1_fwd_data2_q <= s1_fwd_data2_d;
            out_valid_q    <= out_valid_d;
            out_rs1_addr_q <= out_rs1_addr_d;
            out_rs2_addr_q <= out_rs2_addr_d;
            out_rs1_q      <= out_rs1_d;
            out_rs2_q      <= out_rs2_d;
            out_tag_q      <= out_tag_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_rs1_data = out_rs1_q;
    assign out_rs2_data = out_rs2_q;
    assign out_tag      = out_tag_q;

`ifdef OPERAND_FETCH_PERF_EN
    logic [31:0] perf_fwd_q, perf_fwd_d, perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fwd_d   = perf_fwd_q + (fwd_evt ? 32'd1 : 32'd0);
        perf_stall_d = perf_stall_q + ((in_valid && !in_ready) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fwd_q   <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            perf_fwd_q   <= perf_fwd_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fwd_cnt   = perf_fwd_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    logic unused_perf;
    assign unused_perf = fwd_evt;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized traffic
// checked against an in-order request queue and the architectural register contents.
module tb_operand_fetch;

    localparam int TAG_W = 8;

    logic             clk, rst_n, flush, in_valid, in_ready;
    logic [4:0]       in_rs1, in_rs2, rf_rs1_addr, rf_rs2_addr, wb_addr;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [31:0]      rf_rs1_data, rf_rs2_data, wb_data, out_rs1_data, out_rs2_data;
    logic             wb_en, out_valid, out_ready;
`ifdef OPERAND_FETCH_PERF_EN
    logic [31:0]      perf_fwd_cnt, perf_stall_cnt;
`endif

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
    } req_t;

    int          checks = 0;
    int          errors = 0;
    int          pushed = 0;
    int          popped = 0;
    int          stall_model = 0;
    logic        last_in_ready, last_accept;
    logic [31:0] rf_mem [32];
    req_t        sb [$];

    operand_fetch #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_tag(out_tag)
`ifdef OPERAND_FETCH_PERF_EN
        ,
        .perf_fwd_cnt(perf_fwd_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file environment: registered reads return pre-write data, x0 stays zero.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'd0;
        end else begin
            rf_rs1_data <= rf_mem[rf_rs1_addr];
            rf_rs2_data <= rf_mem[rf_rs2_addr];
            if (wb_en && wb_addr != 5'd0) rf_mem[wb_addr] <= wb_data;
        end
    end

    task checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] archValue(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : rf_mem[a];
    endfunction

    // Drives one cycle of inputs from a negedge, scoreboards it, and returns at the next negedge.
    task applyStimulus(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [TAG_W-1:0] t, input logic ordy, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, input logic fl);
        req_t f;
        in_valid = v; in_rs1 = r1; in_rs2 = r2; in_tag = t;
        out_ready = ordy; wb_en = we; wb_addr = wa; wb_data = wd; flush = fl;
        #1;
        last_in_ready = in_ready;
        last_accept   = v && in_ready && !fl;
        if (v && !in_ready) stall_model++;
        if (out_valid) begin
            checkOutput("out_valid_has_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                f = sb[0];
                checkOutput("sb_tag", 32'(out_tag), 32'(f.tag));
                checkOutput("sb_rs1", out_rs1_data, archValue(f.rs1));
                checkOutput("sb_rs2", out_rs2_data, archValue(f.rs2));
                if (ordy) begin
                    void'(sb.pop_front());
                    popped++;
                end
            end
        end
        if (fl) sb.delete();
        else if (last_accept) begin
            sb.push_back('{t, r1, r2});
            pushed++;
        end
        @(negedge clk);
    endtask

    task idleCycle(input logic ordy);
        applyStimulus(1'b0, 5'd0, 5'd0, '0, ordy, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task writeReg(input logic [4:0] a, input logic [31:0] d);
        applyStimulus(1'b0, 5'd0, 5'd0, '0, 1'b1, 1'b1, a, d, 1'b0);
    endtask

    initial begin
        int pu0, po0, nreq;
        logic ir2;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_rs1", out_rs1_data, 32'd0);
        checkOutput("rst_out_rs2", out_rs2_data, 32'd0);
        checkOutput("rst_out_tag", 32'(out_tag), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        writeReg(5'd5, 32'h11);
        writeReg(5'd6, 32'h22);
        writeReg(5'd7, 32'h1);
        writeReg(5'd9, 32'h1);
        idleCycle(1'b1);

        // Basic latency and single pulse
        applyStimulus(1'b1, 5'd5, 5'd6, 8'h03, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("lat_n1_valid", 32'(out_valid), 32'd0);
        idleCycle(1'b1);
        checkOutput("lat_n2_valid", 32'(out_valid), 32'd1);
        checkOutput("lat_n2_rs1", out_rs1_data, 32'h11);
        checkOutput("lat_n2_rs2", out_rs2_data, 32'h22);
        checkOutput("lat_n2_tag", 32'(out_tag), 32'h03);
        idleCycle(1'b1);
        checkOutput("single_pulse", 32'(out_valid), 32'd0);

        // x0 ignores writeback
        applyStimulus(1'b1, 5'd0, 5'd0, 8'h04, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(1'b0, 5'd0, 5'd0, 8'h00, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        checkOutput("x0_valid", 32'(out_valid), 32'd1);
        checkOutput("x0_rs1", out_rs1_data, 32'd0);
        checkOutput("x0_rs2", out_rs2_data, 32'd0);

        // Forward captured in the accept cycle
        applyStimulus(1'b1, 5'd7, 5'd0, 8'h05, 1'b1, 1'b1, 5'd7, 32'hABCD, 1'b0);
        idleCycle(1'b1);
        checkOutput("fwd_b_rs1", out_rs1_data, 32'hABCD);
        writeReg(5'd7, 32'h1);
        idleCycle(1'b1);

        // Forward from a write in the transfer cycle
        applyStimulus(1'b1, 5'd7, 5'd0, 8'h06, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 5'd0, 8'h00, 1'b1, 1'b1, 5'd7, 32'hABCD, 1'b0);
        checkOutput("fwd_a_valid", 32'(out_valid), 32'd1);
        checkOutput("fwd_a_tag", 32'(out_tag), 32'h06);
        checkOutput("fwd_a_rs1", out_rs1_data, 32'hABCD);
        idleCycle(1'b1);

        // Output held for 5 cycles while x9 is rewritten, 10-request burst
        pu0 = pushed; po0 = popped; nreq = 0; ir2 = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            applyStimulus(nreq < 10, 5'($urandom_range(0, 31)), 5'd9, 8'(8'h40 + nreq),
                          cyc >= 5, (cyc == 2) || (cyc == 3), 5'd9,
                          (cyc == 2) ? 32'h55 : 32'h66, 1'b0);
            if (cyc == 2) ir2 = last_in_ready;
            if (last_accept) nreq++;
            if (cyc == 4) begin
                checkOutput("hold_valid", 32'(out_valid), 32'd1);
                checkOutput("hold_tag", 32'(out_tag), 32'h40);
                checkOutput("hold_rs2", out_rs2_data, 32'h66);
            end
        end
        checkOutput("hold_in_ready", 32'(ir2), 32'd0);
        checkOutput("hold_accepted", 32'(pushed - pu0), 32'd10);
        checkOutput("hold_emitted", 32'(popped - po0), 32'd10);

        // Back-to-back requests come out on consecutive cycles in order
        for (int i = 0; i < 10; i++) begin
            applyStimulus(i < 8, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          8'(8'h80 + i), 1'b1, 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 7)), $urandom, 1'b0);
            if (i >= 1 && i <= 8) begin
                checkOutput("b2b_valid", 32'(out_valid), 32'd1);
                checkOutput("b2b_tag", 32'(out_tag), 32'(8'h80 + i - 1));
            end
        end

        // Flush mid-burst
        for (int i = 0; i < 9; i++) begin
            applyStimulus(i < 6, 5'($urandom_range(1, 7)), 5'($urandom_range(1, 7)),
                          8'(8'hA0 + i), 1'b1, 1'b0, 5'd0, 32'd0, i == 3);
            if (i == 3) checkOutput("flush_valid", 32'(out_valid), 32'd0);
            if (i == 5) checkOutput("post_flush_tag", 32'(out_tag), 32'hA4);
        end

        // Asynchronous reset mid-burst
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 5'd5, 5'd6, 8'(8'hC0 + i), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_in_ready", 32'(in_ready), 32'd1);
`ifdef OPERAND_FETCH_PERF_EN
        checkOutput("arst_perf_fwd", perf_fwd_cnt, 32'd0);
        checkOutput("arst_perf_stall", perf_stall_cnt, 32'd0);
`endif
        sb.delete();
        stall_model = 0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) idleCycle(1'b1);

        // Randomized traffic with forwarding collisions and occasional flushes
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 8'(i), $urandom_range(0, 9) < 7,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                          $urandom_range(0, 39) == 0);
        end
        for (int i = 0; i < 5; i++) idleCycle(1'b1);
        checkOutput("drain_empty", 32'(sb.size()), 32'd0);
`ifdef OPERAND_FETCH_PERF_EN
        checkOutput("perf_stall", perf_stall_cnt, 32'(stall_model));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
